alu_cmd_sequencer: RTL and testbench

- Initiator side of the 16-bit combinational ALU interface: accepts operation commands over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU's A/B/Cin/Mode inputs, waits a fixed settle time, then captures Y/Cout/Overflow.
- Writes the result back to the register file and returns it on a valid/ready result port.
- Sits between the lab top-level stimulus logic (switches/FSM) and the ALU instance.

---
 rtl/alu_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer driving a 16-bit combinational ALU: operand fetch, settle wait, capture, writeback, response.
// Optional sticky overflow flag with sticky_clr input, enabled by defining STICKY_OVF_EN.
module alu_cmd_sequencer #(
    parameter int N      = 16,
    parameter int M      = 4,
    parameter int NREG   = 4,
    parameter int SETTLE = 2,
    localparam int IW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [M-1:0]  cmd_mode,
    input  logic [IW-1:0] cmd_srca,
    input  logic [IW-1:0] cmd_srcb,
    input  logic [IW-1:0] cmd_dst,
    input  logic          cmd_cin,
    input  logic [N-1:0]  cmd_imm,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic          alu_cin,
    output logic [M-1:0]  alu_mode,
    input  logic [N-1:0]  alu_y,
    input  logic          alu_cout,
    input  logic          alu_ovf,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_cout,
    output logic          res_ovf
`ifdef STICKY_OVF_EN
    ,
    output logic          sticky_ovf,
    input  logic          sticky_clr
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   dst_q, dst_d;
    logic [N-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic            alu_cin_q, alu_cin_d;
    logic [M-1:0]    alu_mode_q, alu_mode_d;
    logic [N-1:0]    res_data_q, res_data_d;
    logic            res_cout_q, res_cout_d, res_ovf_q, res_ovf_d;
    logic [N-1:0]    rf_q [NREG];
    logic            rf_we;
    logic [IW-1:0]   rf_waddr;
    logic [N-1:0]    rf_wdata;
    logic            flags_pass;

    // Only the arithmetic modes drive Cout/Overflow meaningfully.
    assign flags_pass = (alu_mode_q == M'(4)) || (alu_mode_q == M'(5));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dst_d      = dst_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_mode_d = alu_mode_q;
        res_data_d = res_data_q;
        res_cout_d = res_cout_q;
        res_ovf_d  = res_ovf_q;
        rf_we      = 1'b0;
        rf_waddr   = dst_q;
        rf_wdata   = alu_y;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        rf_we      = 1'b1;
                        rf_waddr   = cmd_dst;
                        rf_wdata   = cmd_imm;
                        res_data_d = cmd_imm;
                        res_cout_d = 1'b0;
                        res_ovf_d  = 1'b0;
                        state_d    = RESP;
                    end else begin
                        alu_a_d    = rf_q[cmd_srca];
                        alu_b_d    = rf_q[cmd_srcb];
                        alu_cin_d  = cmd_cin;
                        alu_mode_d = cmd_mode;
                        dst_d      = cmd_dst;
                        cnt_d      = 4'(SETTLE - 1);
                        state_d    = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) state_d = CAPTURE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            CAPTURE: begin
                rf_we      = 1'b1;
                res_data_d = alu_y;
                res_cout_d = flags_pass & alu_cout;
                res_ovf_d  = flags_pass & alu_ovf;
                state_d    = RESP;
            end
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dst_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_mode_q <= '0;
            res_data_q <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dst_q      <= dst_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_mode_q <= alu_mode_d;
            res_data_q <= res_data_d;
            res_cout_q <= res_cout_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    // Register file must clear on reset, so it is built from flops rather than RAM.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                  rf_q[gi] <= '0;
            else if (rf_we && (rf_waddr == IW'(gi)))  rf_q[gi] <= rf_wdata;
        end
    end

`ifdef STICKY_OVF_EN
    logic sticky_q, sticky_d;
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr)                                        sticky_d = 1'b0;
        else if ((state_q == CAPTURE) && flags_pass && alu_ovf) sticky_d = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_q <= 1'b0;
        else     sticky_q <= sticky_d;
    end
    assign sticky_ovf = sticky_q;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_mode  = alu_mode_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU; expected values are hand-computed constants.
// Exercises the sticky overflow ports when STICKY_OVF_EN is defined.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_load = 1'b0, cmd_cin = 1'b0;
    logic [3:0]  cmd_mode = '0;
    logic [1:0]  cmd_srca = '0, cmd_srcb = '0, cmd_dst = '0;
    logic [15:0] cmd_imm = '0;
    logic        cmd_ready;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        alu_cin, alu_cout, alu_ovf;
    logic [3:0]  alu_mode;
    logic        res_valid, res_cout, res_ovf;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
`ifdef STICKY_OVF_EN
    logic        sticky_ovf;
    logic        sticky_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int lat;
    logic [15:0] held;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.N(16), .M(4), .NREG(4), .SETTLE(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_mode(cmd_mode), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_dst(cmd_dst), .cmd_cin(cmd_cin), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_mode(alu_mode),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_ovf(res_ovf)
`ifdef STICKY_OVF_EN
        , .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
`endif
    );

    // Behavioural ALU: add/sub for modes 4/5; other modes leave Cout/Overflow floating high.
    logic [15:0] b_eff;
    logic [16:0] sum;
    always_comb begin
        b_eff    = (alu_mode == 4'd5) ? ~alu_b : alu_b;
        sum      = {1'b0, alu_a} + {1'b0, b_eff} + {16'd0, alu_cin};
        alu_y    = alu_a & alu_b;
        alu_cout = 1'b1;
        alu_ovf  = 1'b1;
        if (alu_mode == 4'd4 || alu_mode == 4'd5) begin
            alu_y    = sum[15:0];
            alu_cout = sum[16];
            alu_ovf  = (alu_a[15] == b_eff[15]) && (sum[15] != alu_a[15]);
        end else if (alu_mode == 4'd9) begin
            alu_y = alu_a ^ alu_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive_cmd(input logic ld, input logic [3:0] mode, input logic [1:0] sa,
                             input logic [1:0] sb, input logic [1:0] d, input logic cin,
                             input logic [15:0] imm);
        int n;
        @(negedge clk);
        cmd_load = ld; cmd_mode = mode; cmd_srca = sa; cmd_srcb = sb;
        cmd_dst = d; cmd_cin = cin; cmd_imm = imm; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Latency counts the accept cycle as 1.
    task automatic wait_resp(output int cyc);
        cyc = 1;
        @(negedge clk);
        while (!res_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!res_valid) chk("res_valid_timeout", res_valid, 1);
    endtask

    task automatic take(input string tag, input logic [15:0] d, input logic co, input logic ov);
        chk({tag, "_data"}, res_data, d);
        chk({tag, "_cout"}, res_cout, co);
        chk({tag, "_ovf"}, res_ovf, ov);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk({tag, "_idle_ready"}, cmd_ready, 1);
        chk({tag, "_idle_valid"}, res_valid, 0);
        $display("txn %s data=%h cout=%0b ovf=%0b", tag, res_data, res_cout, res_ovf);
    endtask

    task automatic run(input string tag, input logic ld, input logic [3:0] mode, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [1:0] d, input logic cin, input logic [15:0] imm,
                       input logic [15:0] ed, input logic ec, input logic eo);
        int c;
        drive_cmd(ld, mode, sa, sb, d, cin, imm);
        wait_resp(c);
        chk({tag, "_lat"}, c, ld ? 1 : 4);
        take(tag, ed, ec, eo);
    endtask

    initial begin
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_mode", {alu_cin, alu_mode}, 0);
        @(negedge clk);
        rst = 1'b0;

        run("ld_r0", 1, 4'd0, 0, 0, 0, 0, 16'h7FFF, 16'h7FFF, 0, 0);
        run("ld_r1", 1, 4'd0, 0, 0, 1, 0, 16'h0001, 16'h0001, 0, 0);
        run("add_ovf", 0, 4'd4, 0, 1, 2, 0, 16'h0, 16'h8000, 0, 1);
        chk("add_ovf_alu_a", alu_a, 16'h7FFF);
        chk("add_ovf_alu_b", alu_b, 16'h0001);
        run("rd_r2", 0, 4'd4, 2, 3, 3, 0, 16'h0, 16'h8000, 0, 0);
        run("xor_mask", 0, 4'd9, 0, 1, 3, 0, 16'h0, 16'h7FFE, 0, 0);
        run("sub", 0, 4'd5, 0, 1, 3, 1, 16'h0, 16'h7FFE, 1, 0);
        run("ld_r0b", 1, 4'd0, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);

        // Backpressure: hold the response and try to slip a load into r1.
        drive_cmd(0, 4'd4, 0, 1, 2, 0, 16'h0);
        wait_resp(lat);
        chk("add_cout_lat", lat, 4);
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            cmd_load = 1'b1; cmd_dst = 2'd1; cmd_imm = 16'h1234; cmd_valid = (i == 2);
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, held);
            chk("bp_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        take("add_cout", 16'h0000, 1, 0);
        run("r1_kept", 0, 4'd4, 1, 1, 3, 0, 16'h0, 16'h0002, 0, 0);

        // Reset during DRIVE.
        drive_cmd(0, 4'd4, 0, 1, 2, 0, 16'h0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_alu_a", alu_a, 0);
        @(negedge clk);
        rst = 1'b0;
        run("rst_regs", 0, 4'd4, 0, 1, 2, 0, 16'h0, 16'h0000, 0, 0);

`ifdef STICKY_OVF_EN
        chk("sticky_init", sticky_ovf, 0);
        run("s_ld0", 1, 4'd0, 0, 0, 0, 0, 16'h7FFF, 16'h7FFF, 0, 0);
        run("s_ld1", 1, 4'd0, 0, 0, 1, 0, 16'h0001, 16'h0001, 0, 0);
        run("s_ovf", 0, 4'd4, 0, 1, 2, 0, 16'h0, 16'h8000, 0, 1);
        chk("sticky_set", sticky_ovf, 1);
        run("s_clean", 0, 4'd4, 1, 1, 2, 0, 16'h0, 16'h0002, 0, 0);
        chk("sticky_hold", sticky_ovf, 1);
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_clr", sticky_ovf, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
